apb_fpu_add_ctrl: RTL

//  APB slave front end that sits directly upstream of the FPU adder stage.
//  - Holds OP1/OP2 in registers and launches one add or sub per CMD write.
//  - Captures the adder's registered Result on valid and reports done/error status.
//  - Raises a level interrupt on done/error.

---
 rtl/apb_fpu_add_ctrl_if.sv | 24 ++
 rtl/apb_fpu_add_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/apb_fpu_add_ctrl_if.sv
// APB bus bundle for the FPU adder control block.
// The master modport drives requests and the slave modport answers them.
interface apb_fpu_add_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_fpu_add_ctrl.sv
// APB front end for the FPU adder. It holds the operands, launches one add or sub
// per CMD write, captures the result or a timeout, and raises a level interrupt.
module apb_fpu_add_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    apb_fpu_add_ctrl_if.slave     apb,
    output logic [31:0]           fpu_op1,
    output logic [31:0]           fpu_op2,
    output logic                  fpu_add_select,
    output logic                  fpu_sub_select,
    output logic                  fpu_enable,
    input  logic [31:0]           fpu_result,
    input  logic                  fpu_valid,
    output logic                  irq
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] A_OP1    = 3'd0;
    localparam logic [2:0] A_OP2    = 3'd1;
    localparam logic [2:0] A_CMD    = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_RESULT = 3'd4;
    localparam logic [2:0] A_IRQ_EN = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state, state_nxt;
    logic            op_sub;
    logic [31:0]     result;
    logic            done, err;
    logic [1:0]      irq_en;
    logic [CW-1:0]   cnt;
    logic            wait_done, wait_timeout;

    // Address bits outside [4:2] are don't-care; the decode aliases across them.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{apb.paddr[ADDR_WIDTH-1:5], apb.paddr[1:0]};

    logic       xfer, wr, busy, mapped, wr_err, wr_ok, launch;
    logic [2:0] idx;
    logic [1:0] cmd_bits;

    assign xfer     = apb.psel & apb.penable;
    assign wr       = xfer & apb.pwrite;
    assign idx      = apb.paddr[4:2];
    assign cmd_bits = apb.pwdata[1:0];
    assign busy     = (state != S_IDLE);
    assign mapped   = (idx <= A_IRQ_EN);

    // Operand and command registers are locked for the whole operation.
    assign wr_err = wr & mapped &
                    ((busy & (idx == A_OP1 || idx == A_OP2 || idx == A_CMD)) |
                     (idx == A_CMD && cmd_bits == 2'b11));
    assign wr_ok  = wr & mapped & ~wr_err;
    assign launch = wr_ok & (idx == A_CMD) & (cmd_bits == 2'b01 || cmd_bits == 2'b10);

    assign apb.pready  = 1'b1;
    assign apb.pslverr = xfer & (~mapped | wr_err);

    always_comb begin
        apb.prdata = '0;
        if (apb.psel && !apb.pwrite) begin
            case (idx)
                A_OP1:    apb.prdata = fpu_op1;
                A_OP2:    apb.prdata = fpu_op2;
                A_STATUS: apb.prdata = {29'd0, err, done, busy};
                A_RESULT: apb.prdata = result;
                A_IRQ_EN: apb.prdata = {30'd0, irq_en};
                default:  apb.prdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        fpu_add_select = 1'b0;
        fpu_sub_select = 1'b0;
        fpu_enable     = 1'b0;
        wait_done      = 1'b0;
        wait_timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                fpu_add_select = ~op_sub;
                fpu_sub_select = op_sub;
                fpu_enable     = 1'b1;
                state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_valid) begin
                    wait_done = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    wait_timeout = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fpu_op1 <= '0;
            fpu_op2 <= '0;
            op_sub  <= 1'b0;
            result  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            irq_en  <= '0;
            cnt     <= '0;
        end else begin
            if (wr_ok && idx == A_OP1)    fpu_op1 <= apb.pwdata;
            if (wr_ok && idx == A_OP2)    fpu_op2 <= apb.pwdata;
            if (wr_ok && idx == A_IRQ_EN) irq_en  <= apb.pwdata[1:0];
            if (launch)                   op_sub  <= cmd_bits[1];
            if (wait_done)                result  <= fpu_result;

            // A status set in the same cycle as its W1C clear wins.
            if (wait_done)
                done <= 1'b1;
            else if (launch || (wr_ok && idx == A_STATUS && apb.pwdata[1]))
                done <= 1'b0;

            if (wait_timeout)
                err <= 1'b1;
            else if (launch || (wr_ok && idx == A_STATUS && apb.pwdata[2]))
                err <= 1'b0;

            if (state == S_WAIT) cnt <= cnt + 1'b1;
            else                 cnt <= '0;
        end
    end

    assign irq = (irq_en[0] & done) | (irq_en[1] & err);
endmodule
